// File: rtl/fetch_decode_pipe_pkg.sv
// Shared core definitions: opcodes, immediate formats,
// instruction field positions.
package core_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    localparam int OPC_LSB   = 0;
    localparam int RD_LSB    = 7;
    localparam int FUNC_LSB  = 12;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;
    localparam int FUNC7_LSB = 25;

endpackage

// File: rtl/fetch_decode_pipe_if.sv
// Decoded-bundle channel from the front end to the
// register-file/execute stage (valid/ready).
interface fetch_decode_pipe_if #(
    parameter int PC_W = 8
);
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [6:0]      opcode;
    logic [4:0]      rd_addr;
    logic [2:0]      func;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [6:0]      func7;
    logic [31:0]     imm;
    logic            illegal;

    modport master (
        output out_valid, out_pc, out_instr, opcode, rd_addr, func,
        output rs1_addr, rs2_addr, func7, imm, illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pc, out_instr, opcode, rd_addr, func,
        input  rs1_addr, rs2_addr, func7, imm, illegal,
        output out_ready
    );
endinterface

// File: rtl/fetch_decode_pipe_imm_gen.sv
// Combinational immediate generator: picks the format from
// the opcode, sign-extends, and flags unsupported opcodes.
module imm_gen
    import core_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output imm_fmt_e    fmt,
    output logic        illegal
);

    // Opcode -> format, then format -> immediate bit layout
    always_comb begin
        fmt     = FMT_R;
        illegal = 1'b0;
        imm     = '0;
        unique case (instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            OP_REG, OP_SYSTEM:        fmt = FMT_R;
            default:                  illegal = 1'b1;
        endcase
        unique case (fmt)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'b0};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_pipe.sv
// Two-stage fetch/decode front end: PC -> F (imem read)
// -> D (decoded, registered) with valid/ready and redirect.
module fetch_decode_pipe
    import core_pkg::*;
#(
    parameter int              IMEM_DEPTH = 256,
    parameter int              PC_W       = $clog2(IMEM_DEPTH),
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_we,
    input  logic [PC_W-1:0]     imem_waddr,
    input  logic [31:0]         imem_wdata,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    fetch_decode_pipe_if.master dec_o
);

    logic [31:0]     mem [IMEM_DEPTH];
    logic [31:0]     f_instr_q;

    logic [PC_W-1:0] pc_q, pc_d;
    logic            f_valid_q, f_valid_d;
    logic [PC_W-1:0] f_pc_q, f_pc_d;
    logic            out_valid_q, out_valid_d;
    logic [PC_W-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic [31:0]     out_imm_q, out_imm_d;
    logic            out_illegal_q, out_illegal_d;

    logic [31:0]     dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;
    logic            adv;

    assign adv = !out_valid_q || dec_o.out_ready;

    imm_gen u_imm_gen (
        .instr   (f_instr_q),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    // Instruction memory: load port plus read-first fetch port
    always_ff @(posedge clk) begin
        if (imem_we && !rst) begin
            mem[imem_waddr] <= imem_wdata;
        end
        if (adv && !rst && !redirect_valid) begin
            f_instr_q <= mem[pc_q];
        end
    end

    // Next-state for PC, F and D: redirect beats stall
    always_comb begin
        pc_d          = pc_q;
        f_valid_d     = f_valid_q;
        f_pc_d        = f_pc_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_instr_d   = out_instr_q;
        out_imm_d     = out_imm_q;
        out_illegal_d = out_illegal_q;
        if (redirect_valid) begin
            pc_d        = redirect_pc;
            f_valid_d   = 1'b0;
            out_valid_d = 1'b0;
        end else if (adv) begin
            pc_d          = pc_q + PC_W'(1);
            f_valid_d     = 1'b1;
            f_pc_d        = pc_q;
            out_valid_d   = f_valid_q;
            out_pc_d      = f_pc_q;
            out_instr_d   = f_instr_q;
            out_imm_d     = (dec_fmt == FMT_R) ? '0 : dec_imm;
            out_illegal_d = dec_illegal;
        end
    end

    // Pipeline state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            f_valid_q     <= 1'b0;
            f_pc_q        <= '0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_instr_q   <= '0;
            out_imm_q     <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            f_valid_q     <= f_valid_d;
            f_pc_q        <= f_pc_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_instr_q   <= out_instr_d;
            out_imm_q     <= out_imm_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    assign dec_o.out_valid = out_valid_q;
    assign dec_o.out_pc    = out_pc_q;
    assign dec_o.out_instr = out_instr_q;
    assign dec_o.opcode    = out_instr_q[OPC_LSB +: 7];
    assign dec_o.rd_addr   = out_instr_q[RD_LSB +: 5];
    assign dec_o.func      = out_instr_q[FUNC_LSB +: 3];
    assign dec_o.rs1_addr  = out_instr_q[RS1_LSB +: 5];
    assign dec_o.rs2_addr  = out_instr_q[RS2_LSB +: 5];
    assign dec_o.func7     = out_instr_q[FUNC7_LSB +: 7];
    assign dec_o.imm       = out_imm_q;
    assign dec_o.illegal   = out_illegal_q;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Directed bench: 256-deep front end plus a 16-deep
// instance starting at pc 14 to exercise PC wrap.
module tb_fetch_decode_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       we_a = 1'b0;
    logic [7:0] waddr_a = '0;
    logic [31:0] wdata_a = '0;
    logic       redir_a = 1'b0;
    logic [7:0] rpc_a = '0;

    logic       we_b = 1'b0;
    logic [3:0] waddr_b = '0;
    logic [31:0] wdata_b = '0;
    logic       redir_b = 1'b0;
    logic [3:0] rpc_b = '0;

    int n_pass = 0;
    int n_total = 0;

    fetch_decode_pipe_if #(.PC_W(8)) bus_a ();
    fetch_decode_pipe_if #(.PC_W(4)) bus_b ();

    fetch_decode_pipe #(
        .IMEM_DEPTH (256)
    ) u_a (
        .clk            (clk),
        .rst            (rst),
        .imem_we        (we_a),
        .imem_waddr     (waddr_a),
        .imem_wdata     (wdata_a),
        .redirect_valid (redir_a),
        .redirect_pc    (rpc_a),
        .dec_o          (bus_a.master)
    );

    fetch_decode_pipe #(
        .IMEM_DEPTH (16),
        .RESET_PC   (4'd14)
    ) u_b (
        .clk            (clk),
        .rst            (rst),
        .imem_we        (we_b),
        .imem_waddr     (waddr_b),
        .imem_wdata     (wdata_b),
        .redirect_valid (redir_b),
        .redirect_pc    (rpc_b),
        .dec_o          (bus_b.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    logic [31:0] prog [6];

    initial begin
        prog[0] = 32'h00500093;
        prog[1] = 32'h00208133;
        prog[2] = 32'hFE20CEE3;
        prog[3] = 32'h123450B7;
        prog[4] = 32'h0000007F;
        prog[5] = 32'hFE112E23;
        bus_a.out_ready = 1'b0;
        bus_b.out_ready = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            we_b    = 1'b1;
            waddr_b = 4'(i);
            wdata_b = 32'h100 + 32'(i);
            we_a    = (i < 7);
            if (i < 6) begin
                waddr_a = 8'(i);
                wdata_a = prog[i];
            end else begin
                waddr_a = 8'h80;
                wdata_a = 32'h00A00113;
            end
            step();
        end
        we_a = 1'b0;
        we_b = 1'b0;

        rst = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_pc", 32'(bus_a.out_pc), 32'd0);
        chk("rst_instr", bus_a.out_instr, 32'd0);

        rst = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        step();
        chk("first_valid_e1", 32'(bus_a.out_valid), 32'd0);
        step();
        chk("pc0_valid", 32'(bus_a.out_valid), 32'd1);
        chk("pc0_pc", 32'(bus_a.out_pc), 32'd0);
        chk("pc0_rd", 32'(bus_a.rd_addr), 32'd1);
        chk("pc0_imm", bus_a.imm, 32'd5);
        chk("pc0_ill", 32'(bus_a.illegal), 32'd0);
        chk("b_pc14", 32'(bus_b.out_pc), 32'd14);
        chk("b_instr14", bus_b.out_instr, 32'h10E);

        step();
        chk("pc1_pc", 32'(bus_a.out_pc), 32'd1);
        chk("pc1_rd", 32'(bus_a.rd_addr), 32'd2);
        chk("pc1_rs1", 32'(bus_a.rs1_addr), 32'd1);
        chk("pc1_rs2", 32'(bus_a.rs2_addr), 32'd2);
        chk("pc1_f7", 32'(bus_a.func7), 32'd0);
        chk("pc1_imm", bus_a.imm, 32'd0);
        chk("b_pc15", 32'(bus_b.out_pc), 32'd15);

        step();
        chk("pc2_pc", 32'(bus_a.out_pc), 32'd2);
        chk("pc2_op", 32'(bus_a.opcode), 32'h63);
        chk("pc2_imm", bus_a.imm, 32'hFFFFFFFC);
        chk("b_pc0", 32'(bus_b.out_pc), 32'd0);

        step();
        chk("pc3_pc", 32'(bus_a.out_pc), 32'd3);
        chk("pc3_rd", 32'(bus_a.rd_addr), 32'd1);
        chk("pc3_imm", bus_a.imm, 32'h12345000);
        chk("b_pc1", 32'(bus_b.out_pc), 32'd1);
        chk("b_valid", 32'(bus_b.out_valid), 32'd1);

        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("stall_valid", 32'(bus_a.out_valid), 32'd1);
        chk("stall_pc", 32'(bus_a.out_pc), 32'd3);
        chk("stall_instr", bus_a.out_instr, 32'h123450B7);
        chk("stall_imm", bus_a.imm, 32'h12345000);

        bus_a.out_ready = 1'b1;
        step();
        chk("pc4_pc", 32'(bus_a.out_pc), 32'd4);
        chk("pc4_ill", 32'(bus_a.illegal), 32'd1);
        chk("pc4_valid", 32'(bus_a.out_valid), 32'd1);
        step();
        chk("pc5_pc", 32'(bus_a.out_pc), 32'd5);
        chk("pc5_imm", bus_a.imm, 32'hFFFFFFFC);
        chk("pc5_ill", 32'(bus_a.illegal), 32'd0);

        bus_a.out_ready = 1'b0;
        redir_a = 1'b1;
        rpc_a   = 8'h80;
        step();
        redir_a = 1'b0;
        chk("redir_flush", 32'(bus_a.out_valid), 32'd0);
        step();
        chk("redir_e1", 32'(bus_a.out_valid), 32'd0);
        step();
        chk("redir_valid", 32'(bus_a.out_valid), 32'd1);
        chk("redir_pc", 32'(bus_a.out_pc), 32'h80);
        chk("redir_rd", 32'(bus_a.rd_addr), 32'd2);
        chk("redir_imm", bus_a.imm, 32'd10);
        step();
        chk("redir_hold", 32'(bus_a.out_pc), 32'h80);

        rst     = 1'b1;
        redir_a = 1'b1;
        rpc_a   = 8'h40;
        step();
        chk("rst2_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst2_pc", 32'(bus_a.out_pc), 32'd0);
        chk("rst2_instr", bus_a.out_instr, 32'd0);
        chk("rst2_imm", bus_a.imm, 32'd0);
        chk("rst2_rd", 32'(bus_a.rd_addr), 32'd0);

        rst     = 1'b0;
        redir_a = 1'b0;
        bus_a.out_ready = 1'b1;
        step();
        step();
        chk("rst2_refetch_v", 32'(bus_a.out_valid), 32'd1);
        chk("rst2_refetch_pc", 32'(bus_a.out_pc), 32'd0);
        chk("rst2_refetch_i", bus_a.out_instr, 32'h00500093);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_decode_pipe.md
Name: fetch_decode_pipe

Overview:
Parametrised two-stage instruction fetch/decode front end for the 32-bit RV32I-style core. It holds a local instruction memory that is loadable at run time and keeps a word-addressed PC. It decodes each instruction into register addresses, funct fields and a sign-extended immediate. Results go downstream over a valid/ready handshake, with stall back-pressure and branch redirect/flush. It feeds the register-file/execute stage.

Parameters:
IMEM_DEPTH, 256, instruction words in local memory (power of two)
PC_W, $clog2(IMEM_DEPTH), PC width (word address)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
imem_we  in  1  write strobe for instruction memory load
imem_waddr  in  PC_W  load word address
imem_wdata  in  32  load data
redirect_valid  in  1  branch/jump taken; flush and refetch
redirect_pc  in  PC_W  new fetch word address
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts bundle
out_pc  out  PC_W  word address of decoded instruction
out_instr  out  32  raw instruction
opcode  out  7  instr[6:0]
rd_addr  out  5  instr[11:7]
func  out  3  instr[14:12]
rs1_addr  out  5  instr[19:15]
rs2_addr  out  5  instr[24:20]
func7  out  7  instr[31:25]
imm  out  32  sign-extended immediate per format
illegal  out  1  opcode not in supported set

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset (rst=1 at an edge): PC<=RESET_PC, F-valid<=0, out_valid<=0, all output fields<=0. Reset overrides redirect, stall and imem_we. Memory contents are kept.
- Pipeline: PC -> F register (instr, pc, f_valid) -> D/output register. If PC=A at edge N, the instruction is in F after edge N+1 and on the outputs with out_valid=1 after edge N+2, with no stalls.
- Advance condition: adv = !out_valid | out_ready. If adv=1, F advances into D, the memory is read at PC, and PC<=PC+1. If adv=0, PC, F and D all hold. Outputs are bit-stable while out_valid=1 and out_ready=0.
- PC wrap: PC=IMEM_DEPTH-1 increments to 0.
- First fetch after reset: f_valid becomes 1 one edge after rst deasserts. The first out_valid appears two edges after rst deasserts.
- Redirect (no reset): redirect_valid=1 at an edge sets PC<=redirect_pc, f_valid<=0 and out_valid<=0, whatever out_ready is. Redirect has priority over stall. The instruction at redirect_pc appears on the outputs two edges later if not stalled. Back-to-back redirects: the last one wins.
- Memory: synchronous read, with IMEM_DEPTH x 32 storage. When imem_we=1, writes to the same address in the same cycle return the old data (read-first). Writes happen regardless of stall.
- imm by opcode:
  - I (0000011, 0010011, 1100111): {20{i[31]}, i[31:20]}
  - S (0100011): {20{i[31]}, i[31:25], i[11:7]}
  - B (1100011): {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}
  - U (0110111, 0010111): {i[31:12], 12'b0}
  - J (1101111): {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}
  - R (0110011) and others: 0
- illegal=1 for any opcode outside these ten. The bundle is still delivered with out_valid=1. Decode does not trap.
- Field outputs are registered in the D stage, with no combinational path from out_ready to the outputs. out_ready feeds back combinationally only to the stage enables.

Decomposition:
- Shared package `core_pkg`: opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_SYSTEM), an imm-format enum (FMT_R/I/S/B/U/J), and field bit-position constants.
- One sub-module: `imm_gen` (combinational, instr[31:0] -> imm[31:0], fmt, illegal), instantiated ahead of the D register.
- The memory array stays inline.

Test Plan:
- Load mem[0..3]=0x00500093, 0x00208133, 0xFE20CEE3, 0x123450B7; release rst; out_ready=1 -> out_valid rises 2 edges after release. Expected bundles in order:
  - pc 0: rd=1, imm=5
  - pc 1: rd=2, rs1=1, rs2=2, func7=0
  - pc 2: B-type, imm=0xFFFFFFFC
  - pc 3: rd=1, imm=0x12345000
- Hold out_ready=0 for 5 cycles mid-stream -> all outputs and out_pc unchanged. After release, each PC is delivered exactly once, none skipped or duplicated.
- Assert redirect_valid with redirect_pc=0x80 while out_ready=0 -> out_valid=0 next edge. The next delivered out_pc=0x80, two edges later.
- IMEM_DEPTH=16, run from pc 14 -> delivered out_pc sequence 14, 15, 0, 1.
- Opcode 0x7F, and store 0xFE112E23 -> illegal=1 for 0x7F; the store gives imm=0xFFFFFFFC, illegal=0.
- Assert rst during stalled out_valid=1 -> next edge out_valid=0, fields=0, PC=RESET_PC. A simultaneous redirect is ignored.
